lector_contadores: RTL
======================

// Module: lector_contadores
// PURPOSE
//  Downstream consumer of the per-FIFO pop counter. Once the datapath goes idle it sweeps all
//  counters in order: drives req/idx, captures data_out on valid, stores each count and a total.
//  Gives a single coherent snapshot of words popped per FIFO to the end-of-test checker.
// PARAMETERS
//  NUM_CNT   5  number of counters polled (idx 0..NUM_CNT-1)
//  CNT_W     5  width of one counter value (data_out)
//  IDX_W     3  width of idx
//  TOT_W     8  width of total (>= CNT_W+clog2(NUM_CNT))
//  TIMEOUT   4  cycles to wait for valid before a slot is given up
// PORTS
//  clk          in   1               system clock, all logic on posedge
//  reset_L      in   1               synchronous active-low reset
//  idle         in   1               datapath idle; rising edge starts a sweep
//  valid_c      in   1               counter response valid
//  data_out     in   CNT_W           counter value for the requested idx
//  req          out  1               read request to counter
//  idx          out  IDX_W           counter being read
//  cnt_bus      out  NUM_CNT*CNT_W   captured counts, slot i at [i*CNT_W +: CNT_W]
//  total        out  TOT_W           sum of captured counts in current/last sweep
//  busy         out  1               sweep in progress
//  done         out  1               one-cycle pulse, sweep completed
//  timeout_err  out  1               sticky: a slot timed out since last sweep start
//  aborted      out  1               one-cycle pulse, sweep cancelled by idle falling
// BEHAVIOUR
//  - Reset (reset_L=0 at posedge): state S_IDLE; req=0, idx=0, cnt_bus=0, total=0, busy=0,
//    done=0, timeout_err=0, aborted=0, idle_q=0. Reset mid-sweep: same, no done/aborted.
//  - idle_q registers idle; start = idle & ~idle_q, honoured only in S_IDLE.
//  - FSM, all outputs registered:
//    S_IDLE: on start -> S_REQ; idx=0, total=0, cnt_bus=0, timeout_err=0, busy=1.
//    S_REQ : req=1, idx stable; -> S_WAIT next cycle, wait_cnt=0.
//    S_WAIT: req held 1. If valid_c: slot[idx]=data_out, total+=data_out (zero-extended).
//            Else wait_cnt++; if wait_cnt==TIMEOUT-1: slot[idx]=0, timeout_err=1.
//            After capture/timeout: idx==NUM_CNT-1 -> S_DONE, else idx++ -> S_REQ.
//            req drops to 0 in the cycle after capture (one-cycle gap between requests).
//    S_DONE: done=1 for one cycle, busy=0, req=0, idx=0 -> S_IDLE.
//  - Latency: valid_c sampled at earliest one cycle after req first rises; minimum sweep
//    = 2*NUM_CNT+1 cycles from start to done (11 at defaults).
//  - Abort: idle=0 in S_REQ/S_WAIT -> S_IDLE next cycle, req=0, busy=0, aborted=1 one
//    cycle; slots/total keep partial values. Abort wins over simultaneous valid_c (no capture).
//  - valid_c outside S_WAIT ignored. start while busy ignored. idle held high after done does
//    not retrigger; a new 0->1 edge is required.
//  - total never wraps at defaults (5*31=155 < 256); addition truncated to TOT_W otherwise.
//  - idx never exceeds NUM_CNT-1.
// STRUCTURE
//  - Shared package: state encodings S_IDLE/S_REQ/S_WAIT/S_DONE (2 bits), default widths
//    NUM_CNT/CNT_W/IDX_W, FIFO index constants 0..4.
//  - One sub-module natural: temporizador_espera (clear/enable wait counter, expired flag at
//    TIMEOUT-1). Everything else flat in this module.
// TESTING
//  1 Reset hold 2 cycles, then release -> all outputs 0, state S_IDLE, req never asserts.
//  2 Counters preloaded 4,4,4,4,4 (4 pops per FIFO), idle 0->1 -> req/idx 0..4, cnt_bus each
//    slot 4, total=20, done pulse exactly once, busy high 11 cycles with 1-cycle valid.
//  3 valid_c withheld for idx=2 -> slot2=0 after 4 wait cycles, timeout_err=1, sweep
//    continues to idx=4, done=1, total = sum of other slots.
//  4 idle falls while waiting on idx=3 -> aborted=1 one cycle, req=0 next cycle, slots 0..2
//    kept, no done; new idle rise restarts from idx=0 with timeout_err cleared.
//  5 Counters 31,31,31,31,31 -> total=155, no wrap; idle held high afterwards -> no 2nd sweep.
//  6 reset_L=0 pulsed mid-sweep at idx=1 -> next cycle everything at reset values, no done.

Source files
------------

// File: rtl/lector_contadores_pkg.sv
// Shared types and default sizes for the counter sweep reader.
// No logic, so no latency and no flow control.
package lector_contadores_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int NUM_CNT_DEF = 5;
  localparam int CNT_W_DEF   = 5;
  localparam int IDX_W_DEF   = 3;
  localparam int TOT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 4;

  localparam logic [IDX_W_DEF-1:0] FIFO_0 = 3'd0;
  localparam logic [IDX_W_DEF-1:0] FIFO_1 = 3'd1;
  localparam logic [IDX_W_DEF-1:0] FIFO_2 = 3'd2;
  localparam logic [IDX_W_DEF-1:0] FIFO_3 = 3'd3;
  localparam logic [IDX_W_DEF-1:0] FIFO_4 = 3'd4;

endpackage

// File: rtl/lector_contadores_if.sv
// Request/response link between the sweep reader (master) and the pop counter (slave).
// Combinational wiring only; the counter answers a held req with a valid_c pulse.
interface lector_contadores_if
  import lector_contadores_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             req;
  logic [IDX_W-1:0] idx;
  logic             valid_c;
  logic [CNT_W-1:0] data_out;

  modport master (output req, output idx, input valid_c, input data_out);
  modport slave  (input req, input idx, output valid_c, output data_out);

endinterface

// File: rtl/lector_contadores_espera.sv
// Wait counter for one outstanding counter read; expired_o is high once TIMEOUT-1 idle
// cycles have been counted. Registered count, combinational flag, saturates until cleared.
module temporizador_espera #(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic reset_L,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lector_contadores.sv
// Sweeps all pop counters on an idle rising edge and holds a snapshot plus total.
// Two cycles per slot (req, capture), done one cycle after the last slot; idle dropping aborts.
module lector_contadores
  import lector_contadores_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int TOT_W   = TOT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     idle,
  lector_contadores_if.master      cnt_if,
  output logic [NUM_CNT*CNT_W-1:0] cnt_bus,
  output logic [TOT_W-1:0]         total,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic                     aborted
);

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             req_q, req_d;
  logic [NUM_CNT-1:0][CNT_W-1:0]    slot_q, slot_d;
  logic [TOT_W-1:0]                 total_q, total_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             terr_q, terr_d;
  logic                             abort_q, abort_d;
  logic                             idle_q;

  logic             start;
  logic             expired;
  logic             wr_en;
  logic [CNT_W-1:0] wr_val;
  logic             advance;

  assign start = idle & ~idle_q;

  temporizador_espera #(.TIMEOUT(TIMEOUT)) u_espera (
    .clk       (clk),
    .reset_L   (reset_L),
    .clear_i   (state_q == S_REQ),
    .enable_i  ((state_q == S_WAIT) && !cnt_if.valid_c),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    req_d   = req_q;
    slot_d  = slot_q;
    total_d = total_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    terr_d  = terr_q;
    abort_d = 1'b0;
    wr_en   = 1'b0;
    wr_val  = '0;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          idx_d   = '0;
          total_d = '0;
          slot_d  = '0;
          terr_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_REQ: begin
        if (!idle) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          abort_d = 1'b1;
        end else begin
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Abort takes priority so a late response never lands in a cancelled sweep.
        if (!idle) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
          abort_d = 1'b1;
        end else if (cnt_if.valid_c) begin
          wr_en   = 1'b1;
          wr_val  = cnt_if.data_out;
          total_d = total_q + TOT_W'(cnt_if.data_out);
          advance = 1'b1;
        end else if (expired) begin
          wr_en   = 1'b1;
          terr_d  = 1'b1;
          advance = 1'b1;
        end
        if (advance) begin
          req_d = 1'b0;
          if (idx_q == IDX_W'(NUM_CNT - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NUM_CNT; i++) begin
      if (wr_en && (idx_q == IDX_W'(i))) begin
        slot_d[i] = wr_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      req_q   <= 1'b0;
      slot_q  <= '0;
      total_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      abort_q <= 1'b0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      slot_q  <= slot_d;
      total_q <= total_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      abort_q <= abort_d;
      idle_q  <= idle;
    end
  end

  assign cnt_if.req   = req_q;
  assign cnt_if.idx   = idx_q;
  assign cnt_bus      = slot_q;
  assign total        = total_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = terr_q;
  assign aborted      = abort_q;

endmodule
